// File: rtl/ec_fp_addsub_srv_if.sv
// Streaming interface carrying word data plus sop/eop framing, error flag,
// byte modulus and a ctl tag, with sink/source views.
interface if_axi_stream #(
  parameter int unsigned DAT_BITS = 64,
  parameter int unsigned CTL_BITS = 8,
  parameter int unsigned MOD_BITS = (DAT_BITS / 8 > 1) ? $clog2(DAT_BITS / 8) : 1
) ();
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;

  modport sink   (input  val, sop, eop, err, dat, mod, ctl, output rdy);
  modport source (output val, sop, eop, err, dat, mod, ctl, input  rdy);
endinterface

// File: rtl/ec_fp_addsub_srv.sv
// Modular add/sub server over GF(P): one shared datapath, word-serial I/O.
// Define EC_FP_ADDSUB_CHK_EN to flag framing errors on the result's err bit.
module ec_fp_addsub_srv #(
  parameter int unsigned     BITS       = 256,
  parameter int unsigned     ARITH_BITS = 64,
  parameter logic [BITS-1:0] P          = '0,
  parameter int unsigned     CTL_BITS   = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  if_axi_stream.sink    i_add_if,
  if_axi_stream.sink    i_sub_if,
  if_axi_stream.source  o_add_if,
  if_axi_stream.source  o_sub_if
);
  localparam int unsigned DIV   = BITS / ARITH_BITS;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, EMIT} state_t;

  state_t                  state, state_nxt;
  logic                    sel_sub, last_sub, phase;
  logic [CNT_W-1:0]        cnt;
  logic [BITS-1:0]         a_q, b_q, r_q;
  logic [BITS:0]           s_q;
  logic [CTL_BITS-1:0]     ctl_q;

  logic                    in_val, in_rdy, in_fire, in_sop, in_eop;
  logic [2*ARITH_BITS-1:0] in_dat;
  logic [CTL_BITS-1:0]     in_ctl;
  logic                    out_val, out_rdy, out_fire, last_beat, grant_sub;
  logic                    emit_add, emit_sub, frame_err;

  always_comb begin
    in_val    = sel_sub ? i_sub_if.val : i_add_if.val;
    in_sop    = sel_sub ? i_sub_if.sop : i_add_if.sop;
    in_eop    = sel_sub ? i_sub_if.eop : i_add_if.eop;
    in_dat    = sel_sub ? i_sub_if.dat : i_add_if.dat;
    in_ctl    = sel_sub ? i_sub_if.ctl : i_add_if.ctl;
    in_rdy    = (state == COLLECT);
    in_fire   = in_val && in_rdy;
    out_val   = (state == EMIT);
    out_rdy   = sel_sub ? o_sub_if.rdy : o_add_if.rdy;
    out_fire  = out_val && out_rdy;
    last_beat = (cnt == CNT_W'(DIV - 1));
    // On contention the sink not served last wins; last_sub resets to 1 so add goes first.
    grant_sub = i_sub_if.val && (!i_add_if.val || !last_sub);
    emit_add  = out_val && !sel_sub;
    emit_sub  = out_val && sel_sub;
  end

  assign i_add_if.rdy = in_rdy && !sel_sub;
  assign i_sub_if.rdy = in_rdy && sel_sub;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_add_if.val || i_sub_if.val) state_nxt = COLLECT;
      COLLECT: if (in_fire && last_beat)         state_nxt = COMPUTE;
      COMPUTE: if (phase)                        state_nxt = EMIT;
      EMIT:    if (out_fire && last_beat)        state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sel_sub  <= 1'b0;
      last_sub <= 1'b1;
      phase    <= 1'b0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      s_q      <= '0;
      ctl_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          phase <= 1'b0;
          if (i_add_if.val || i_sub_if.val) begin
            sel_sub  <= grant_sub;
            last_sub <= grant_sub;
          end
        end
        COLLECT: if (in_fire) begin
          // LS word arrives first, so words enter at the top and shift down.
          a_q <= (a_q >> ARITH_BITS) | (BITS'(in_dat[ARITH_BITS-1:0]) << (BITS - ARITH_BITS));
          b_q <= (b_q >> ARITH_BITS) | (BITS'(in_dat[2*ARITH_BITS-1:ARITH_BITS]) << (BITS - ARITH_BITS));
          if (cnt == '0) ctl_q <= in_ctl;
          cnt <= last_beat ? '0 : cnt + 1'b1;
        end
        COMPUTE: begin
          phase <= ~phase;
          if (!phase) begin
            s_q <= sel_sub ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
          end else if (sel_sub) begin
            r_q <= s_q[BITS] ? (s_q[BITS-1:0] + P) : s_q[BITS-1:0];
          end else begin
            r_q <= (s_q >= {1'b0, P}) ? BITS'(s_q - {1'b0, P}) : s_q[BITS-1:0];
          end
        end
        EMIT: if (out_fire) begin
          r_q <= r_q >> ARITH_BITS;
          cnt <= last_beat ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef EC_FP_ADDSUB_CHK_EN
  logic beat_bad;
  always_comb
    beat_bad = (in_sop != (cnt == '0)) || (in_eop != last_beat) ||
               ((cnt != '0) && (in_ctl != ctl_q));

  always_ff @(posedge i_clk) begin
    if (!i_rst || state == IDLE)  frame_err <= 1'b0;
    else if (in_fire && beat_bad) frame_err <= 1'b1;
  end
`else
  assign frame_err = 1'b0;
`endif

  assign o_add_if.val = emit_add;
  assign o_add_if.sop = emit_add && (cnt == '0);
  assign o_add_if.eop = emit_add && last_beat;
  assign o_add_if.err = emit_add && frame_err;
  assign o_add_if.dat = emit_add ? r_q[ARITH_BITS-1:0] : '0;
  assign o_add_if.ctl = emit_add ? ctl_q : '0;
  assign o_add_if.mod = '0;

  assign o_sub_if.val = emit_sub;
  assign o_sub_if.sop = emit_sub && (cnt == '0);
  assign o_sub_if.eop = emit_sub && last_beat;
  assign o_sub_if.err = emit_sub && frame_err;
  assign o_sub_if.dat = emit_sub ? r_q[ARITH_BITS-1:0] : '0;
  assign o_sub_if.ctl = emit_sub ? ctl_q : '0;
  assign o_sub_if.mod = '0;

  logic unused_ok;
  assign unused_ok = &{1'b0, i_add_if.err, i_add_if.mod, i_sub_if.err, i_sub_if.mod,
                       in_sop, in_eop};
endmodule

// File: doc/ec_fp_addsub_srv.md
EC_FP_ADDSUB_SRV -- requirements
Module: ec_fp_addsub_srv

Interface
REQ-001 The block SHALL have a parameter BITS, default 256, giving the field element width in bits.
REQ-002 The block SHALL have a parameter ARITH_BITS, default 64, giving the word width; BITS SHALL be an integer multiple of it, and DIV = BITS/ARITH_BITS.
REQ-003 The block SHALL have a parameter P, default 0 (BITS wide), giving the prime modulus; it must be set at instantiation.
REQ-004 The block SHALL have a parameter CTL_BITS, default 8, giving the ctl tag width.
REQ-005 Port i_clk, input, 1 bit: the single clock.
REQ-006 Port i_rst, input, 1 bit: synchronous active-low reset.
REQ-007 Port i_add_if, if_axi_stream.sink, dat 2*ARITH_BITS: addition requests, one word per beat, dat[0 +: ARITH_BITS] = a word and dat[ARITH_BITS +: ARITH_BITS] = b word.
REQ-008 Port i_sub_if, if_axi_stream.sink, dat 2*ARITH_BITS: subtraction requests computing a-b, with the same word layout as i_add_if.
REQ-009 Port o_add_if, if_axi_stream.source, dat ARITH_BITS: addition results.
REQ-010 Port o_sub_if, if_axi_stream.source, dat ARITH_BITS: subtraction results.
REQ-011 On all ports, words SHALL be least-significant first; a transaction is DIV beats, sop on beat 0 and eop on beat DIV-1.

Function
REQ-012 States: IDLE, COLLECT, COMPUTE, EMIT; a single shared datapath serves one transaction at a time.
REQ-013 IDLE arbitration: if only one sink has val, grant it; if both have val, grant the sink not granted last; after reset the priority goes to add.
REQ-014 rdy SHALL be high only on the granted sink, only in COLLECT, and rdy of the other sink SHALL be low.
REQ-015 COLLECT: each accepted beat shifts the a and b words into BITS-wide registers, and ctl is latched from the beat-0 word.
REQ-016 The DIV-th accepted beat SHALL move COLLECT to COMPUTE.
REQ-017 COMPUTE cycle 1, add: s = a+b, BITS+1 wide.
REQ-018 COMPUTE cycle 1, sub: d = a-b with borrow.
REQ-019 COMPUTE cycle 2, add: r = s-P if s>=P, else r = s.
REQ-020 COMPUTE cycle 2, sub: r = d+P if borrow, else r = d.
REQ-021 Then go to EMIT.
REQ-022 Inputs are required to be < P; no range check is made, and the result for out-of-range inputs is the formula above truncated to BITS.
REQ-023 EMIT drives DIV beats on the matching source, LS word first, with sop/eop per REQ-011 and ctl equal to the latched ctl.
REQ-024 An EMIT beat advances only when val&&rdy; dat, ctl, sop and eop SHALL be held stable while val=1 and rdy=0.
REQ-025 After the eop beat is accepted, go to IDLE with val low on the next cycle; the pipeline is not overlapped.
REQ-026 Latency: the first output beat is valid 3 cycles after the input eop is accepted, with no backpressure.
REQ-027 Throughput: one transaction per 2*DIV+3 cycles.
REQ-028 A result of zero and DIV=1 SHALL be handled without special cases; for DIV=1 the single beat carries both sop and eop.
REQ-029 The unused source SHALL hold val=0.
REQ-030 mod and err SHALL be 0 on both sources unless REQ-033 applies.

Reset
REQ-031 When i_rst=0 at a clock edge: state becomes IDLE, both source val/sop/eop/err and dat/ctl are 0, both sink rdy are 0, the word counter is 0, and priority goes to add.
REQ-032 Reset mid-transaction SHALL discard partial operands and any in-flight result without emitting them.

Configuration
REQ-033 With EC_FP_ADDSUB_CHK_EN defined, a framing error SHALL set err=1 on every beat of that transaction's result and continue counting to DIV beats. Framing errors are: sop missing on beat 0, sop on a later beat, eop before beat DIV-1, eop missing on beat DIV-1, or ctl changing within the transaction.
REQ-034 With EC_FP_ADDSUB_CHK_EN undefined, there is no checking logic, err is tied 0, and only the beat count delimits transactions.

Verification (bench parameters BITS=32, ARITH_BITS=8, DIV=4, P=0xFFFFFFFB)
REQ-035 Add with wrap: a=0xFFFFFFFA, b=0x00000002, ctl=0x10 -> o_add_if emits 0x01,0x00,0x00,0x00 with ctl 0x10, first beat 3 cycles after the input eop.
REQ-036 Sub with borrow: a=0x00000001, b=0x00000002, ctl=0x09 -> o_sub_if emits 0xFA,0xFF,0xFF,0xFF.
REQ-037 Contention: both sinks valid in the same cycle after reset -> add is served first, then sub; on the next contention sub is served first.
REQ-038 Backpressure: hold o_add_if.rdy=0 for 5 cycles on beat 2 -> the beat is held stable and the full result is still correct.
REQ-039 Reset mid-transaction: i_rst=0 after 2 input beats, then a new add a=3, b=4 -> only 0x07,0,0,0 is emitted.
REQ-040 Framing check: with EC_FP_ADDSUB_CHK_EN, eop on beat 1 -> all 4 result beats have err=1; without the macro, err stays 0.
